// File: rtl/alu_word_seq.sv
// Byte-serial word ALU sequencer driving a shared 8-bit ALU, LSB first.
// Optional signed overflow flag: define ALU_SEQ_SIGNED_OVF_EN.
module alu_word_seq #(
   parameter int BYTES = 4,
   localparam int W = 8 * BYTES
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [2:0]   op,
   input  logic [W-1:0] opa,
   input  logic [W-1:0] opb,
   input  logic         cin,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] result,
   output logic         carry_out,
   output logic         zero_out,
   output logic         ovf_out,
   output logic [7:0]   alu_a,
   output logic [7:0]   alu_b,
   output logic [2:0]   alu_fn,
   output logic         alu_cin,
   input  logic [7:0]   alu_out,
   input  logic         alu_c,
   input  logic         alu_z
);

   localparam int IW = $clog2(BYTES);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t         state, state_nx;
   logic [2:0]     op_q;
   logic [W-1:0]   a_q, b_q, res_q;
   logic           cin_q, carry_q, zacc_q;
   logic [IW-1:0]  idx;
   logic           last, arith;

   assign last  = (idx == IW'(BYTES - 1));
   assign arith = ~op_q[2];

   assign busy      = (state != IDLE);
   assign done      = (state == DONE);
   assign result    = res_q;
   assign carry_out = carry_q;
   assign zero_out  = zacc_q;

   always_comb begin
      state_nx = state;
      alu_a    = '0;
      alu_b    = '0;
      alu_fn   = '0;
      alu_cin  = 1'b0;
      unique case (state)
         IDLE: if (start) state_nx = RUN;
         RUN: begin
            alu_a = a_q[8*idx +: 8];
            alu_b = b_q[8*idx +: 8];
            if (idx == '0) begin
               alu_fn  = op_q;
               alu_cin = arith & op_q[0] & cin_q;
            end else if (arith) begin
               // upper bytes always chain through the carry-in variant
               alu_fn  = {op_q[2:1], 1'b1};
               alu_cin = carry_q;
            end else begin
               alu_fn  = op_q;
            end
            if (last) state_nx = DONE;
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         cin_q   <= 1'b0;
         idx     <= '0;
         res_q   <= '0;
         carry_q <= 1'b0;
         zacc_q  <= 1'b0;
      end else begin
         state <= state_nx;
         unique case (state)
            IDLE: if (start) begin
               op_q    <= op;
               a_q     <= opa;
               b_q     <= opb;
               cin_q   <= cin;
               idx     <= '0;
               carry_q <= 1'b0;
               zacc_q  <= 1'b1;
            end
            RUN: begin
               res_q[8*idx +: 8] <= alu_out;
               carry_q <= alu_c & arith;
               zacc_q  <= zacc_q & alu_z;
               idx     <= idx + 1'b1;
            end
            default: ;
         endcase
      end
   end

`ifdef ALU_SEQ_SIGNED_OVF_EN
   logic ovf_q, a_msb, b_msb, r_msb;

   assign a_msb   = a_q[W-1];
   assign b_msb   = b_q[W-1];
   assign r_msb   = alu_out[7];
   assign ovf_out = ovf_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_q <= 1'b0;
      end else if (state == IDLE && start) begin
         ovf_q <= 1'b0;
      end else if (state == RUN && last) begin
         if (!arith)
            ovf_q <= 1'b0;
         else if (!op_q[1])
            ovf_q <= (a_msb == b_msb) && (r_msb != a_msb);
         else
            ovf_q <= (a_msb != b_msb) && (r_msb != a_msb);
      end
   end
`else
   assign ovf_out = 1'b0;
`endif

endmodule

// File: tb/tb_alu_word_seq.sv
// Scoreboard bench for alu_word_seq with a byte ALU model and word-level reference.
module tb_alu_word_seq;
   localparam int BYTES = 4;
   localparam int W = 8 * BYTES;

   logic         clk = 1'b0;
   logic         rst, start, cin;
   logic [2:0]   op;
   logic [W-1:0] opa, opb;
   logic         busy, done, carry_out, zero_out, ovf_out;
   logic [W-1:0] result;
   logic [7:0]   alu_a, alu_b, alu_out;
   logic [2:0]   alu_fn;
   logic         alu_cin, alu_c, alu_z;

   alu_word_seq #(.BYTES(BYTES)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op),
      .opa(opa), .opb(opb), .cin(cin),
      .busy(busy), .done(done), .result(result),
      .carry_out(carry_out), .zero_out(zero_out), .ovf_out(ovf_out),
      .alu_a(alu_a), .alu_b(alu_b), .alu_fn(alu_fn), .alu_cin(alu_cin),
      .alu_out(alu_out), .alu_c(alu_c), .alu_z(alu_z)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // shared 8-bit ALU the sequencer drives
   logic [8:0] t;
   always_comb begin
      t = '0;
      case (alu_fn)
         3'd0: t = {1'b0, alu_a} + {1'b0, alu_b};
         3'd1: t = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_cin};
         3'd2: t = {1'b0, alu_a} - {1'b0, alu_b};
         3'd3: t = {1'b0, alu_a} - {1'b0, alu_b} - {8'd0, alu_cin};
         3'd4: t = {1'b0, alu_a & alu_b};
         3'd5: t = {1'b0, alu_a | alu_b};
         3'd6: t = {1'b0, alu_a ^ alu_b};
         default: t = {1'b0, alu_a & ~alu_b};
      endcase
      alu_out = t[7:0];
      alu_c   = (alu_fn < 3'd4) ? t[8] : 1'b0;
      alu_z   = (t[7:0] == 8'd0);
   end

   typedef struct {
      logic [W-1:0] r;
      logic c, z, v;
      int acc;
   } exp_t;

   exp_t sb[$];
   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [W-1:0] act,
                      input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", name, act, exp);
      end
   endtask

   function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] a,
                                  input logic [W-1:0] b, input logic c);
      exp_t e;
      logic [W:0] s;
      case (o)
         3'd0: s = {1'b0, a} + {1'b0, b};
         3'd1: s = {1'b0, a} + {1'b0, b} + (W+1)'(c);
         3'd2: s = {1'b0, a} - {1'b0, b};
         3'd3: s = {1'b0, a} - {1'b0, b} - (W+1)'(c);
         3'd4: s = {1'b0, a & b};
         3'd5: s = {1'b0, a | b};
         3'd6: s = {1'b0, a ^ b};
         default: s = {1'b0, a & ~b};
      endcase
      e.r = s[W-1:0];
      e.c = (o < 3'd4) ? s[W] : 1'b0;
      e.z = (e.r == '0);
      e.v = 1'b0;
`ifdef ALU_SEQ_SIGNED_OVF_EN
      if (o < 3'd2)
         e.v = (a[W-1] == b[W-1]) && (e.r[W-1] != a[W-1]);
      else if (o < 3'd4)
         e.v = (a[W-1] != b[W-1]) && (e.r[W-1] != a[W-1]);
`endif
      e.acc = 0;
      return e;
   endfunction

   always @(negedge clk) begin
      if (!rst && done === 1'b1) begin
         if (sb.size() == 0) begin
            chk("done_unexpected", W'(done), '0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("result", result, e.r);
            chk("carry_out", W'(carry_out), W'(e.c));
            chk("zero_out", W'(zero_out), W'(e.z));
            chk("ovf_out", W'(ovf_out), W'(e.v));
            chk("busy_at_done", W'(busy), W'(1'b1));
            chk("latency", W'(cyc), W'(e.acc + BYTES));
         end
      end
   end

   task automatic issue(input logic [2:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic c);
      exp_t e;
      int n = 0;
      @(negedge clk);
      while (busy && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (busy) chk("issue_timeout", W'(busy), '0);
      op = o; opa = a; opb = b; cin = c; start = 1'b1;
      e = model(o, a, b, c);
      e.acc = cyc + 1;
      sb.push_back(e);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((sb.size() != 0 || busy) && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("drain", W'(sb.size()), '0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      logic [2:0] o;
      logic [W-1:0] a, b;
      int n;
      rst = 1'b1; start = 1'b0; op = '0; opa = '0; opb = '0; cin = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_busy", W'(busy), '0);
      chk("rst_done", W'(done), '0);
      chk("rst_result", result, '0);
      chk("rst_carry", W'(carry_out), '0);
      chk("rst_zero", W'(zero_out), '0);
      chk("rst_ovf", W'(ovf_out), '0);
      chk("rst_alu_a", W'(alu_a), '0);
      chk("rst_alu_b", W'(alu_b), '0);
      chk("rst_alu_fn", W'(alu_fn), '0);
      chk("rst_alu_cin", W'(alu_cin), '0);
      rst = 1'b0;

      issue(3'd0, 32'h0000_00FF, 32'h0000_0001, 1'b0);
      issue(3'd2, 32'h0000_0000, 32'h0000_0001, 1'b0);
      issue(3'd3, 32'h0000_0005, 32'h0000_0002, 1'b1);
      issue(3'd1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
      chk("b0_fn", W'(alu_fn), W'(3'd1));
      chk("b0_cin", W'(alu_cin), W'(1'b1));
      for (int i = 1; i < BYTES; i++) begin
         @(negedge clk);
         chk($sformatf("b%0d_fn", i), W'(alu_fn), W'(3'd1));
         chk($sformatf("b%0d_cin", i), W'(alu_cin), W'(1'b1));
      end
      issue(3'd6, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b0);
      issue(3'd7, 32'hFF00_FF00, 32'h0F0F_0F0F, 1'b0);
      issue(3'd0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
      issue(3'd2, 32'h8000_0000, 32'h0000_0001, 1'b0);
      drain();
      chk("idle_alu_fn", W'(alu_fn), '0);
      chk("idle_alu_a", W'(alu_a), '0);

      issue(3'd0, 32'h1234_5678, 32'h1111_1111, 1'b0);
      @(negedge clk);
      op = 3'd7; opa = 32'hDEAD_BEEF; opb = 32'h0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (done !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("ign_done_seen", W'(done), W'(1'b1));
      op = 3'd5; opa = 32'hCAFE_F00D; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("ign_busy", W'(busy), '0);
      chk("ign_result", result, 32'h2345_6789);
      repeat (3) @(negedge clk);
      chk("ign_busy_later", W'(busy), '0);
      chk("ign_result_later", result, 32'h2345_6789);

      issue(3'd0, 32'h0101_0101, 32'h0202_0202, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      sb.delete();
      @(negedge clk);
      rst = 1'b0;
      chk("abort_busy", W'(busy), '0);
      chk("abort_done", W'(done), '0);
      chk("abort_result", result, '0);
      chk("abort_carry", W'(carry_out), '0);
      repeat (8) @(negedge clk);
      issue(3'd2, 32'h0000_1000, 32'h0000_0FFF, 1'b0);
      drain();

      for (int k = 0; k < 40; k++) begin
         o = 3'($urandom_range(0, 7));
         a = $urandom;
         b = $urandom;
         case ($urandom_range(0, 4))
            0: b = a;
            1: a = '1;
            2: b = ~a;
            3: a = '0;
            default: ;
         endcase
         issue(o, a, b, 1'($urandom_range(0, 1)));
      end
      drain();
      repeat (5) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
